// File: rtl/binarization_output.sv
// binarization_output: decodes thermometer-coded channel words back into
// signed multi-bit pixels. This is the inverse of the input binarization
// stage: pixel p is coded as CH_CNT/2 + p ones filled from bit 0 upward.
// The block is a two-stage valid/ready pipeline (S1, S2) that tracks frame
// position and flags lanes whose code is not a legal thermometer word.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready are both 1. A producer holds its valid and data stable
// until that edge. in_ready depends only on registered state and out_ready,
// never on in_valid. out_* fields stay stable while out_valid && !out_ready.
module binarization_output #(
    parameter int PARAM_IN_CNT = 784,
    parameter int PARAM_IN_BIT = 2,
    parameter int PARAM_CH_CNT = 2**PARAM_IN_BIT,
    parameter int PARAM_LANES  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [PARAM_LANES-1:0][PARAM_CH_CNT-1:0]      in_chan,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0]      out_pixel,
    output logic                                          out_last,
    output logic                                          out_err,
    output logic                                          frame_err
);

    localparam int BEATS = PARAM_IN_CNT / PARAM_LANES;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PC_W  = $clog2(PARAM_CH_CNT + 1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [PARAM_IN_BIT-1:0] HALF     = PARAM_IN_BIT'(PARAM_CH_CNT / 2);

    // Input-side beat index; it is attached to each beat as it enters S1
    // so that stalls further down cannot skew frame position.
    logic [IDX_W-1:0] in_idx_q, in_idx_d;

    // S1: per-lane saturated popcount and malformed flag.
    logic                                     s1_valid_q, s1_valid_d;
    logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0] s1_pop_q,   s1_pop_d;
    logic [PARAM_LANES-1:0]                   s1_bad_q,   s1_bad_d;
    logic [IDX_W-1:0]                         s1_idx_q,   s1_idx_d;

    // S2: decoded pixels, beat error and frame position.
    logic                                     s2_valid_q, s2_valid_d;
    logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0] s2_pix_q,   s2_pix_d;
    logic                                     s2_err_q,   s2_err_d;
    logic [IDX_W-1:0]                         s2_idx_q,   s2_idx_d;

    logic frame_err_q, frame_err_d;

    logic [PARAM_LANES-1:0][PC_W-1:0]         pop_cnt;
    logic [PARAM_LANES-1:0][PARAM_IN_BIT-1:0] pop_sat;
    logic [PARAM_LANES-1:0]                   lane_bad;
    logic                                     s2_adv;
    logic                                     s1_load;
    logic                                     out_xfer;

    // S2 can take new contents when empty or when its beat leaves this cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;

    // Per-lane popcount and legality of the incoming thermometer code.
    // A code c is of the form (1<<k)-1 exactly when c & (c+1) == 0; the
    // all-ones word passes that test but needs k = CH_CNT, so it is illegal.
    always_comb begin
        pop_cnt  = '0;
        pop_sat  = '0;
        lane_bad = '0;
        for (int l = 0; l < PARAM_LANES; l++) begin
            for (int j = 0; j < PARAM_CH_CNT; j++) begin
                pop_cnt[l] = pop_cnt[l] + {{(PC_W-1){1'b0}}, in_chan[l][j]};
            end
            if (pop_cnt[l] > PC_W'(PARAM_CH_CNT - 1)) begin
                pop_sat[l] = '1;
            end else begin
                pop_sat[l] = pop_cnt[l][PARAM_IN_BIT-1:0];
            end
            lane_bad[l] = ((in_chan[l] & (in_chan[l] + PARAM_CH_CNT'(1))) != '0)
                          || (pop_cnt[l] == PC_W'(PARAM_CH_CNT));
        end
    end

    // Next-state for both stages, the beat index and the sticky frame error.
    always_comb begin
        in_idx_d    = in_idx_q;
        s1_valid_d  = s1_valid_q;
        s1_pop_d    = s1_pop_q;
        s1_bad_d    = s1_bad_q;
        s1_idx_d    = s1_idx_q;
        s2_valid_d  = s2_valid_q;
        s2_pix_d    = s2_pix_q;
        s2_err_d    = s2_err_q;
        s2_idx_d    = s2_idx_q;
        frame_err_d = frame_err_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (s1_load) begin
            s1_pop_d = pop_sat;
            s1_bad_d = lane_bad;
            s1_idx_d = in_idx_q;
            in_idx_d = (in_idx_q == LAST_IDX) ? '0 : in_idx_q + 1'b1;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int l = 0; l < PARAM_LANES; l++) begin
                    s2_pix_d[l] = s1_pop_q[l] - HALF;
                end
                s2_err_d = |s1_bad_q;
                s2_idx_d = s1_idx_q;
            end
        end

        // The first beat of a frame restarts the sticky flag from its own error.
        if (out_xfer) begin
            if (s2_idx_q == '0) begin
                frame_err_d = s2_err_q;
            end else begin
                frame_err_d = frame_err_q | s2_err_q;
            end
        end
    end

    // State registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_idx_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_pop_q    <= '0;
            s1_bad_q    <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_pix_q    <= '0;
            s2_err_q    <= 1'b0;
            s2_idx_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            in_idx_q    <= in_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_pop_q    <= s1_pop_d;
            s1_bad_q    <= s1_bad_d;
            s1_idx_q    <= s1_idx_d;
            s2_valid_q  <= s2_valid_d;
            s2_pix_q    <= s2_pix_d;
            s2_err_q    <= s2_err_d;
            s2_idx_q    <= s2_idx_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_pixel = s2_pix_q;
    assign out_err   = s2_err_q;
    assign out_last  = s2_valid_q && (s2_idx_q == LAST_IDX);
    assign frame_err = frame_err_q;

endmodule
